// File: rtl/lsu_mem_master.sv
// rtl/lsu_mem_master.sv - RV32 load/store initiator to word-addressed memory (optional LSU_TIMEOUT_EN wait abort)
module lsu_mem_master #(
    parameter int ADD_WIDTH      = 12,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [2:0]           req_funct3,
    input  logic [31:0]          req_addr,
    input  logic [31:0]          req_wdata,
    output logic                 resp_valid,
    output logic [31:0]          resp_rdata,
    output logic                 resp_err,
    output logic [ADD_WIDTH-1:0] mem_add,
    output logic [31:0]          mem_write_data,
    output logic                 mem_read,
    output logic                 mem_write,
    input  logic                 mem_ready,
    input  logic [31:0]          mem_read_data
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_REQ  = 3'd3,
        WR_WAIT = 3'd4,
        RESP    = 3'd5
    } state_t;

    state_t      state;
    logic        lat_we;
    logic [2:0]  lat_funct3;
    logic [1:0]  lat_lane;
    logic [15:0] lat_wdata;
    logic        req_bad;

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) < 4) ? 4 : $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt;
`endif

    // Address bits above the memory window are dropped so accesses wrap.
    logic unused_inputs;
    assign unused_inputs = ^{req_addr[31:ADD_WIDTH+2], (TIMEOUT_CYCLES != 0)};

    always_comb begin
        req_bad = 1'b0;
        if (req_we)
            req_bad = req_funct3[2] || (req_funct3[1:0] == 2'b11);
        else
            req_bad = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
        if ((req_funct3[1:0] == 2'b01) && req_addr[0])
            req_bad = 1'b1;
        if ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00))
            req_bad = 1'b1;
    end

    function automatic logic [31:0] load_extract(input logic [31:0] w,
                                                 input logic [2:0]  f3,
                                                 input logic [1:0]  lane);
        logic [7:0]  b;
        logic [15:0] h;
        case (lane)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = lane[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'd0, b};
            3'b101:  return {16'd0, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] w,
                                                input logic [15:0] d,
                                                input logic        half,
                                                input logic [1:0]  lane);
        logic [31:0] r;
        r = w;
        if (half) begin
            if (lane[1]) r[31:16] = d;
            else         r[15:0]  = d;
        end else begin
            case (lane)
                2'd0:    r[7:0]   = d[7:0];
                2'd1:    r[15:8]  = d[7:0];
                2'd2:    r[23:16] = d[7:0];
                default: r[31:24] = d[7:0];
            endcase
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            req_ready      <= 1'b0;
            resp_valid     <= 1'b0;
            resp_rdata     <= 32'd0;
            resp_err       <= 1'b0;
            mem_add        <= '0;
            mem_write_data <= 32'd0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            lat_we         <= 1'b0;
            lat_funct3     <= 3'd0;
            lat_lane       <= 2'd0;
            lat_wdata      <= 16'd0;
`ifdef LSU_TIMEOUT_EN
            wait_cnt       <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (!req_ready) begin
                        req_ready <= 1'b1;
                    end else if (req_valid) begin
                        req_ready  <= 1'b0;
                        lat_we     <= req_we;
                        lat_funct3 <= req_funct3;
                        lat_lane   <= req_addr[1:0];
                        lat_wdata  <= req_wdata[15:0];
                        mem_add    <= req_addr[ADD_WIDTH+1:2];
                        if (req_bad) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'd0;
                        end else if (req_we && (req_funct3[1:0] == 2'b10)) begin
                            state          <= WR_REQ;
                            mem_write      <= 1'b1;
                            mem_write_data <= req_wdata;
                        end else begin
                            // Loads and sub-word stores both start with a read.
                            state    <= RD_REQ;
                            mem_read <= 1'b1;
                        end
                    end
                end
                RD_REQ: begin
                    state <= RD_WAIT;
`ifdef LSU_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                RD_WAIT: begin
                    if (mem_ready) begin
                        mem_read <= 1'b0;
                        if (lat_we) begin
                            state          <= WR_REQ;
                            mem_write      <= 1'b1;
                            mem_write_data <= store_merge(mem_read_data, lat_wdata,
                                                          lat_funct3[0], lat_lane);
                        end else begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b0;
                            resp_rdata <= load_extract(mem_read_data, lat_funct3, lat_lane);
                        end
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        state      <= RESP;
                        mem_read   <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_rdata <= 32'd0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                WR_REQ: begin
                    state <= WR_WAIT;
`ifdef LSU_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                WR_WAIT: begin
                    if (mem_ready) begin
                        state      <= RESP;
                        mem_write  <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= 32'd0;
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        state      <= RESP;
                        mem_write  <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_rdata <= 32'd0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                RESP: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    req_ready  <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                    req_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// tb/tb_lsu_mem_master.sv - directed self-checking bench for lsu_mem_master
module tb_lsu_mem_master;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [11:0] mem_add;
    logic [31:0] mem_write_data;
    logic        mem_read;
    logic        mem_write;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_read_data = 32'd0;

    int assertions = 0;
    int failures   = 0;

    logic [31:0] mem [0:4095];
    int extra_wait = 0;
    int stall      = 0;
    int both_cnt   = 0;

    always #5 clk = ~clk;

    lsu_mem_master #(.ADD_WIDTH(12), .TIMEOUT_CYCLES(15)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_add(mem_add), .mem_write_data(mem_write_data),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_ready(mem_ready), .mem_read_data(mem_read_data)
    );

    // Registered memory: answers a request after extra_wait stalled cycles.
    always @(posedge clk) begin
        if (mem_read || mem_write) begin
            if (stall < extra_wait) begin
                stall     <= stall + 1;
                mem_ready <= 1'b0;
            end else begin
                stall     <= 0;
                mem_ready <= 1'b1;
                if (mem_write) mem[mem_add] <= mem_write_data;
                else           mem_read_data <= mem[mem_add];
            end
        end else begin
            stall     <= 0;
            mem_ready <= 1'b0;
        end
    end

    always @(negedge clk) if (mem_read && mem_write) both_cnt <= both_cnt + 1;

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input int bound,
                         output int lat, output logic [31:0] rdata, output logic err,
                         output int rd_cyc, output int wr_cyc,
                         output logic [11:0] add_seen, output logic add_changed);
        int w;
        logic seen;
        lat = -1; rdata = 32'd0; err = 1'b0; rd_cyc = 0; wr_cyc = 0;
        add_seen = 12'd0; add_changed = 1'b0; seen = 1'b0; w = 0;
        @(negedge clk);
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int i = 1; i <= bound; i++) begin
            @(negedge clk);
            if (mem_read)  rd_cyc++;
            if (mem_write) wr_cyc++;
            if (mem_read || mem_write) begin
                if (!seen) begin
                    add_seen = mem_add;
                    seen = 1'b1;
                end else if (mem_add !== add_seen) begin
                    add_changed = 1'b1;
                end
            end
            if (resp_valid) begin
                lat = i; rdata = resp_rdata; err = resp_err;
                break;
            end
        end
    endtask

    int          lat, rc, wc;
    logic [31:0] rd;
    logic        er, chg;
    logic [11:0] ad;

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        assertions++;
        if ({req_ready, resp_valid, resp_err, mem_read, mem_write} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got %b expected 00000", {req_ready, resp_valid, resp_err, mem_read, mem_write});
        end
        assertions++;
        if ({resp_rdata, mem_write_data, mem_add} !== 76'd0) begin
            failures++;
            $display("FAIL reset_data: rdata %h wdata %h add %h expected all 0", resp_rdata, mem_write_data, mem_add);
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        assertions++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready: got %b expected 1", req_ready);
        end
    endtask

    task automatic test_sw_lw();
        issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 20, lat, rd, er, rc, wc, ad, chg);
        assertions++;
        if (lat !== 3 || er !== 1'b0 || ad !== 12'd4 || wc !== 2 || rc !== 0) begin
            failures++;
            $display("FAIL sw_basic: lat %0d err %b add %0d wr %0d rd %0d expected 3 0 4 2 0", lat, er, ad, wc, rc);
        end
        assertions++;
        if (mem[4] !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL sw_mem: got %h expected deadbeef", mem[4]);
        end
        issue(1'b0, 3'b010, 32'h10, 32'd0, 20, lat, rd, er, rc, wc, ad, chg);
        assertions++;
        if (lat !== 3 || rd !== 32'hDEADBEEF || er !== 1'b0 || rc !== 2 || wc !== 0) begin
            failures++;
            $display("FAIL lw_basic: lat %0d rdata %h err %b rd %0d wr %0d expected 3 deadbeef 0 2 0", lat, rd, er, rc, wc);
        end
    endtask

    task automatic test_load_extend();
        logic [31:0] exp_v [5];
        logic [2:0]  f3_v  [5];
        logic [31:0] ad_v  [5];
        exp_v = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000000AA, 32'hFFFFFFAA};
        f3_v  = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000};
        ad_v  = '{32'h13, 32'h13, 32'h12, 32'h10, 32'h10};
        issue(1'b1, 3'b010, 32'h10, 32'h80FF00AA, 20, lat, rd, er, rc, wc, ad, chg);
        for (int i = 0; i < 5; i++) begin
            issue(1'b0, f3_v[i], ad_v[i], 32'd0, 20, lat, rd, er, rc, wc, ad, chg);
            assertions++;
            if (lat !== 3 || rd !== exp_v[i] || er !== 1'b0) begin
                failures++;
                $display("FAIL load_ext[%0d]: lat %0d rdata %h err %b expected 3 %h 0", i, lat, rd, er, exp_v[i]);
            end
        end
    endtask

    task automatic test_sub_store();
        issue(1'b1, 3'b010, 32'h10, 32'h11223344, 20, lat, rd, er, rc, wc, ad, chg);
        issue(1'b1, 3'b000, 32'h11, 32'hFFFFFF55, 20, lat, rd, er, rc, wc, ad, chg);
        assertions++;
        if (lat !== 5 || er !== 1'b0 || rc !== 2 || wc !== 2 || mem[4] !== 32'h11225544) begin
            failures++;
            $display("FAIL sb_rmw: lat %0d err %b rd %0d wr %0d mem %h expected 5 0 2 2 11225544", lat, er, rc, wc, mem[4]);
        end
        issue(1'b1, 3'b001, 32'h12, 32'h0000ABCD, 20, lat, rd, er, rc, wc, ad, chg);
        assertions++;
        if (lat !== 5 || er !== 1'b0 || rd !== 32'd0 || mem[4] !== 32'hABCD5544) begin
            failures++;
            $display("FAIL sh_rmw: lat %0d err %b rdata %h mem %h expected 5 0 0 abcd5544", lat, er, rd, mem[4]);
        end
        issue(1'b1, 3'b010, 32'h4010, 32'h01020304, 20, lat, rd, er, rc, wc, ad, chg);
        assertions++;
        if (ad !== 12'd4 || mem[4] !== 32'h01020304) begin
            failures++;
            $display("FAIL addr_wrap: add %0d mem %h expected 4 01020304", ad, mem[4]);
        end
    endtask

    task automatic test_errors();
        logic        we_v [4];
        logic [2:0]  f3_v [4];
        logic [31:0] ad_v [4];
        we_v = '{1'b0, 1'b1, 1'b0, 1'b1};
        f3_v = '{3'b010, 3'b001, 3'b011, 3'b100};
        ad_v = '{32'h02, 32'h03, 32'h00, 32'h00};
        for (int i = 0; i < 4; i++) begin
            issue(we_v[i], f3_v[i], ad_v[i], 32'h12345678, 20, lat, rd, er, rc, wc, ad, chg);
            assertions++;
            if (lat !== 1 || er !== 1'b1 || rd !== 32'd0 || rc !== 0 || wc !== 0) begin
                failures++;
                $display("FAIL error_req[%0d]: lat %0d err %b rdata %h rd %0d wr %0d expected 1 1 0 0 0", i, lat, er, rd, rc, wc);
            end
        end
    endtask

    task automatic test_delay();
        issue(1'b1, 3'b010, 32'h10, 32'hCAFEF00D, 20, lat, rd, er, rc, wc, ad, chg);
        extra_wait = 3;
        issue(1'b0, 3'b010, 32'h10, 32'd0, 30, lat, rd, er, rc, wc, ad, chg);
        extra_wait = 0;
        assertions++;
        if (lat !== 6 || rd !== 32'hCAFEF00D || rc !== 5 || chg !== 1'b0) begin
            failures++;
            $display("FAIL delayed_lw: lat %0d rdata %h rd %0d addchg %b expected 6 cafef00d 5 0", lat, rd, rc, chg);
        end
    endtask

    task automatic test_reset_mid();
        int pulses;
        pulses = 0;
        extra_wait = 10;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        assertions++;
        if ({req_ready, resp_valid, resp_err, mem_read, mem_write} !== 5'b0 || mem_add !== 12'd0 || resp_rdata !== 32'd0) begin
            failures++;
            $display("FAIL reset_mid: ctrl %b add %h rdata %h expected 0", {req_ready, resp_valid, resp_err, mem_read, mem_write}, mem_add, resp_rdata);
        end
        repeat (2) begin
            @(negedge clk);
            if (resp_valid) pulses++;
        end
        reset = 1'b1;
        extra_wait = 0;
        repeat (4) begin
            @(negedge clk);
            if (resp_valid) pulses++;
        end
        assertions++;
        if (pulses !== 0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_after: resp pulses %0d ready %b expected 0 1", pulses, req_ready);
        end
    endtask

`ifdef LSU_TIMEOUT_EN
    task automatic test_timeout();
        extra_wait = 1000;
        issue(1'b0, 3'b010, 32'h10, 32'd0, 40, lat, rd, er, rc, wc, ad, chg);
        assertions++;
        if (lat !== 17 || er !== 1'b1 || rd !== 32'd0 || rc !== 16 || mem_read !== 1'b0) begin
            failures++;
            $display("FAIL timeout_lw: lat %0d err %b rdata %h rd %0d mem_read %b expected 17 1 0 16 0", lat, er, rd, rc, mem_read);
        end
        extra_wait = 0;
        repeat (2) @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_sw_lw();
        test_load_extend();
        test_sub_store();
        test_errors();
        test_delay();
`ifdef LSU_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        assertions++;
        if (both_cnt !== 0) begin
            failures++;
            $display("FAIL read_write_overlap: got %0d cycles expected 0", both_cnt);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
